// File: rtl/idelay_scan_ctrl.sv
// Eye-scan initiator: sweeps the IDELAY target, dwells on each tap, parks at the widest clean run.
// Optional IDELAY_SCAN_ERRCNT_EN adds per-tap error-count reporting ports.
`timescale 1ns/1ps

module idelay_scan_ctrl #(
    parameter int unsigned TAP_STEP      = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES  = 64,
    parameter int unsigned READY_TIMEOUT = 256
) (
    input  logic        clk160,
    input  logic        rstb,
    input  logic        start,
    input  logic        match,
    input  logic        delay_ready,
    output logic [8:0]  delay_target,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic        timeout,
    output logic [8:0]  best_center,
    output logic [9:0]  best_width
`ifdef IDELAY_SCAN_ERRCNT_EN
    ,
    output logic        tap_result_valid,
    output logic [8:0]  tap_result_tap,
    output logic [15:0] tap_result_errcnt
`endif
);

    localparam int unsigned CNT_MAX_A = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > READY_TIMEOUT) ? CNT_MAX_A : READY_TIMEOUT;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    localparam logic [8:0]  LAST_TAP  = 9'(511 - (511 % TAP_STEP));
    localparam logic [8:0]  STEP      = 9'(TAP_STEP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_SET,
        S_SETTLE,
        S_WAIT_RDY,
        S_DWELL,
        S_EVAL,
        S_FINAL_SET,
        S_FINAL_SETTLE,
        S_FINAL_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [8:0]      tap;
    logic            run_open;
    logic [8:0]      run_start;
    logic [9:0]      run_len;

    logic            hit_settle;
    logic            hit_dwell;
    logic            hit_timeout;
    logic            is_last;
    logic            tap_good;
    logic            eff_open;
    logic [8:0]      eff_start;
    logic [9:0]      eff_len;
    logic [8:0]      eff_center;
    logic            close_now;

`ifdef IDELAY_SCAN_ERRCNT_EN
    logic [15:0]     errcnt;
    assign tap_good          = (errcnt == '0);
    assign tap_result_valid  = (state == S_EVAL);
    assign tap_result_tap    = tap;
    assign tap_result_errcnt = errcnt;
`else
    logic            err_seen;
    assign tap_good = ~err_seen;
`endif

    assign hit_settle  = (cnt == CW'(SETTLE_CYCLES - 1));
    assign hit_dwell   = (cnt == CW'(DWELL_CYCLES - 1));
    assign hit_timeout = (cnt == CW'(READY_TIMEOUT - 1));
    assign is_last     = (tap == LAST_TAP);

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk160) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_SET;
            S_SET:          state_nx = S_SETTLE;
            S_SETTLE:       if (hit_settle) state_nx = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (delay_ready)      state_nx = S_DWELL;
                else if (hit_timeout) state_nx = S_DONE;
            end
            S_DWELL:        if (hit_dwell) state_nx = S_EVAL;
            S_EVAL:         state_nx = is_last ? S_FINAL_SET : S_SET;
            S_FINAL_SET:    state_nx = S_FINAL_SETTLE;
            S_FINAL_SETTLE: if (hit_settle) state_nx = S_FINAL_WAIT;
            S_FINAL_WAIT:   if (delay_ready || hit_timeout) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    // Run as it stands after including this tap; a bad tap leaves the open run untouched so it can be closed.
    always_comb begin
        eff_open   = tap_good | run_open;
        eff_start  = (tap_good && !run_open) ? tap : run_start;
        eff_len    = tap_good ? (run_open ? run_len + 10'd1 : 10'd1) : run_len;
        eff_center = 9'(16'(eff_start) + (((16'(eff_len) - 16'd1) * 16'(TAP_STEP)) >> 1));
        close_now  = ~tap_good | is_last;
    end

    always_ff @(posedge clk160) begin
        if (!rstb) begin
            cnt          <= '0;
            tap          <= '0;
            run_open     <= 1'b0;
            run_start    <= '0;
            run_len      <= '0;
            delay_target <= '0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            best_center  <= '0;
            best_width   <= '0;
`ifdef IDELAY_SCAN_ERRCNT_EN
            errcnt       <= '0;
`else
            err_seen     <= 1'b0;
`endif
        end else begin
            cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        tap         <= '0;
                        run_open    <= 1'b0;
                        run_start   <= '0;
                        run_len     <= '0;
                        best_center <= '0;
                        best_width  <= '0;
                        fail        <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                S_SET: begin
                    delay_target <= tap;
`ifdef IDELAY_SCAN_ERRCNT_EN
                    errcnt       <= '0;
`else
                    err_seen     <= 1'b0;
`endif
                end
                S_WAIT_RDY, S_FINAL_WAIT: begin
                    if (!delay_ready && hit_timeout) begin
                        fail         <= 1'b1;
                        timeout      <= 1'b1;
                        delay_target <= '0;
                    end
                end
                S_DWELL: begin
`ifdef IDELAY_SCAN_ERRCNT_EN
                    if (!match && errcnt != '1) errcnt <= errcnt + 16'd1;
`else
                    if (!match) err_seen <= 1'b1;
`endif
                end
                S_EVAL: begin
                    run_open  <= tap_good & ~is_last;
                    run_start <= eff_start;
                    run_len   <= eff_len;
                    if (close_now && eff_open && (eff_len > best_width)) begin
                        best_width  <= eff_len;
                        best_center <= eff_center;
                    end
                    if (!is_last) tap <= tap + STEP;
                end
                S_FINAL_SET: begin
                    if (best_width == '0) begin
                        fail         <= 1'b1;
                        delay_target <= '0;
                    end else begin
                        delay_target <= best_center;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_idelay_scan_ctrl.sv
// Self-checking bench for idelay_scan_ctrl: setter model, match windows, scoreboard of scan results.
`timescale 1ns/1ps

module tb_idelay_scan_ctrl;

    logic        clk160 = 1'b0;
    logic        rstb   = 1'b0;
    logic        start  = 1'b0;
    logic        match;
    logic        delay_ready;
    logic [8:0]  delay_target;
    logic        busy;
    logic        done;
    logic        fail;
    logic        timeout;
    logic [8:0]  best_center;
    logic [9:0]  best_width;
`ifdef IDELAY_SCAN_ERRCNT_EN
    logic        tap_result_valid;
    logic [8:0]  tap_result_tap;
    logic [15:0] tap_result_errcnt;
    bit          errcnt_on = 1'b0;
    int          n_results = 0;
`endif

    idelay_scan_ctrl #(
        .TAP_STEP      (4),
        .SETTLE_CYCLES (16),
        .DWELL_CYCLES  (64),
        .READY_TIMEOUT (256)
    ) dut (
        .clk160       (clk160),
        .rstb         (rstb),
        .start        (start),
        .match        (match),
        .delay_ready  (delay_ready),
        .delay_target (delay_target),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .timeout      (timeout),
        .best_center  (best_center),
        .best_width   (best_width)
`ifdef IDELAY_SCAN_ERRCNT_EN
        ,
        .tap_result_valid  (tap_result_valid),
        .tap_result_tap    (tap_result_tap),
        .tap_result_errcnt (tap_result_errcnt)
`endif
    );

    always #3 clk160 = ~clk160;

    int lo1 = 1, hi1 = 0, lo2 = 1, hi2 = 0;
    bit stuck = 1'b0;
    bit drop  = 1'b0;

    always_comb begin
        match = 1'b0;
        if ((int'(delay_target) >= lo1 && int'(delay_target) <= hi1) ||
            (int'(delay_target) >= lo2 && int'(delay_target) <= hi2))
            match = ~drop;
    end

    // Setter: ready returns 12 cycles after any target change.
    logic [8:0] set_prev;
    int         set_cnt;
    always @(posedge clk160) begin
        if (!rstb) begin
            set_prev <= '0;
            set_cnt  <= 0;
        end else if (delay_target != set_prev) begin
            set_prev <= delay_target;
            set_cnt  <= 12;
        end else if (set_cnt != 0) begin
            set_cnt <= set_cnt - 1;
        end
    end
    assign delay_ready = !stuck && (set_cnt == 0) && (delay_target == set_prev);

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        string tag;
        int    width;
        int    center;
        bit    fail;
        bit    timeout;
        int    target;
        int    latency;
    } exp_t;

    exp_t sb[$];

`ifdef IDELAY_SCAN_ERRCNT_EN
    always @(negedge clk160) begin
        if (errcnt_on && tap_result_valid) begin
            n_results++;
            check_val($sformatf("errcnt_tap%0d", tap_result_tap), 32'(tap_result_errcnt),
                      (tap_result_tap == 9'd8) ? 32'd1 : 32'd0);
        end
    end
`endif

    task automatic run_scan(input string tag, input int l1, input int h1, input int l2, input int h2,
                            input int ew, input int ec, input bit ef, input bit et, input int etgt,
                            input int elat, input bit mid_start);
        exp_t e;
        int   cyc;
        logic [8:0] c0;
        lo1 = l1; hi1 = h1; lo2 = l2; hi2 = h2;
        e.tag = tag; e.width = ew; e.center = ec; e.fail = ef; e.timeout = et;
        e.target = etgt; e.latency = elat;
        sb.push_back(e);
        @(negedge clk160);
        start = 1'b1;
        @(posedge clk160); #1;
        start = 1'b0;
        cyc = 0;
        check_val({tag, "_busy_n1"}, 32'(busy), 32'd1);
        check_val({tag, "_done_n1"}, 32'(done), 32'd0);
        while (!done && cyc < 12000) begin
            @(posedge clk160); #1;
            cyc++;
            if (mid_start && cyc == 3000) begin
                start = 1'b1;
                @(posedge clk160); #1;
                start = 1'b0;
                cyc++;
            end
        end
        e = sb.pop_front();
        check_val({e.tag, "_done"}, 32'(done), 32'd1);
        check_val({e.tag, "_latency"}, 32'(cyc), 32'(e.latency));
        check_val({e.tag, "_width"}, 32'(best_width), 32'(e.width));
        check_val({e.tag, "_center"}, 32'(best_center), 32'(e.center));
        check_val({e.tag, "_fail"}, 32'(fail), 32'(e.fail));
        check_val({e.tag, "_timeout"}, 32'(timeout), 32'(e.timeout));
        check_val({e.tag, "_target"}, 32'(delay_target), 32'(e.target));
        check_val({e.tag, "_busy"}, 32'(busy), 32'd0);
        c0 = best_center;
        repeat (20) @(posedge clk160);
        #1;
        check_val({e.tag, "_hold_done"}, 32'(done), 32'd1);
        check_val({e.tag, "_hold_center"}, 32'(best_center), 32'(c0));
    endtask

    initial begin
        int n;
        rstb  = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk160);
        #1;
        check_val("rst_start_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_fail", 32'(fail), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_target", 32'(delay_target), 32'd0);
        check_val("rst_center", 32'(best_center), 32'd0);
        check_val("rst_width", 32'(best_width), 32'd0);
        start = 1'b0;
        rstb  = 1'b1;
        repeat (2) @(posedge clk160);
        #1;
        check_val("idle_busy", 32'(busy), 32'd0);

        run_scan("single", 100, 199, 1, 0, 25, 148, 1'b0, 1'b0, 148, 10642, 1'b0);
        run_scan("two_win", 20, 59, 300, 379, 20, 338, 1'b0, 1'b0, 338, 10642, 1'b1);
        run_scan("tie", 0, 39, 400, 439, 10, 18, 1'b0, 1'b0, 18, 10642, 1'b0);
        run_scan("none", 1, 0, 1, 0, 0, 0, 1'b1, 1'b0, 0, 10642, 1'b0);
        run_scan("edge", 480, 511, 1, 0, 8, 494, 1'b0, 1'b0, 494, 10642, 1'b0);

`ifdef IDELAY_SCAN_ERRCNT_EN
        errcnt_on = 1'b1;
        n_results = 0;
`endif
        fork
            run_scan("drop8", 0, 511, 1, 0, 125, 260, 1'b0, 1'b0, 260, 10642, 1'b0);
            begin
                n = 0;
                while (delay_target != 9'd8 && n < 2000) begin
                    @(posedge clk160); #1;
                    n++;
                end
                check_val("drop8_reach", 32'(delay_target), 32'd8);
                repeat (40) @(posedge clk160);
                #1 drop = 1'b1;
                @(posedge clk160);
                #1 drop = 1'b0;
            end
        join
`ifdef IDELAY_SCAN_ERRCNT_EN
        errcnt_on = 1'b0;
        check_val("errcnt_results", 32'(n_results), 32'd128);
`endif

        stuck = 1'b1;
        run_scan("stuck", 0, 511, 1, 0, 0, 0, 1'b1, 1'b1, 0, 273, 1'b0);
        stuck = 1'b0;

        lo1 = 20; hi1 = 59; lo2 = 300; hi2 = 379;
        @(negedge clk160);
        start = 1'b1;
        @(posedge clk160); #1;
        start = 1'b0;
        n = 0;
        while (delay_target != 9'd200 && n < 6000) begin
            @(posedge clk160); #1;
            n++;
        end
        check_val("midrst_reach", 32'(delay_target), 32'd200);
        check_val("midrst_pre_width", 32'(best_width), 32'd10);
        check_val("midrst_pre_busy", 32'(busy), 32'd1);
        rstb = 1'b0;
        @(posedge clk160); #1;
        rstb = 1'b1;
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_done", 32'(done), 32'd0);
        check_val("midrst_fail", 32'(fail), 32'd0);
        check_val("midrst_timeout", 32'(timeout), 32'd0);
        check_val("midrst_target", 32'(delay_target), 32'd0);
        check_val("midrst_center", 32'(best_center), 32'd0);
        check_val("midrst_width", 32'(best_width), 32'd0);
        repeat (30) @(posedge clk160);
        #1;
        check_val("midrst_abandon", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idelay_scan_ctrl.md
# idelay_scan_ctrl

Eye-scan initiator for one input lane. It sweeps the IDELAY tap target across the full 9-bit range and checks the deserialized data at each tap for a dwell window. It then selects the centre of the longest contiguous error-free tap run and parks the lane there. The block drives the `delay_target` / `delay_ready` side of the per-lane IDELAY setter; it never touches the IDELAY primitive directly.

## Interface
Parameters:
- `TAP_STEP`, 4: tap increment per scan point; power of two, 1..64.
- `SETTLE_CYCLES`, 16: holdoff after each target change before `delay_ready` is trusted. Must be ≥ one full setter loop (9 cycles).
- `DWELL_CYCLES`, 64: cycles of `match` sampled per tap; 1..65535.
- `READY_TIMEOUT`, 256: maximum cycles to wait for `delay_ready`.

Ports:
- `clk160`  in  1  lane clock.
- `rstb`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a scan; ignored while `busy`.
- `match`  in  1  per-cycle flag: current deserialized word equals the training pattern.
- `delay_ready`  in  1  from setter: tap count equals target.
- `delay_target`  out  9  requested tap, to setter.
- `busy`  out  1  scan in progress.
- `done`  out  1  level; scan finished; held until next `start`.
- `fail`  out  1  no error-free tap, or ready timeout; valid when `done`.
- `timeout`  out  1  the failure was a ready timeout.
- `best_center`  out  9  chosen tap.
- `best_width`  out  10  length of best run, in scan points.

## Operation
- States: IDLE, SET, SETTLE, WAIT_RDY, DWELL, EVAL, FINAL_SET, FINAL_SETTLE, FINAL_WAIT, DONE.
- IDLE/DONE + `start`: clear run and best registers, `fail`, `timeout`, `done`; set `tap` to 0; go to SET.
- SET: `delay_target <= tap`; go to SETTLE.
- SETTLE: count `SETTLE_CYCLES`, then go to WAIT_RDY.
- WAIT_RDY: when `delay_ready` is 1, go to DWELL. After `READY_TIMEOUT` cycles without it, set `fail` and `timeout`, set `delay_target` to 0, go to DONE.
- DWELL: sample `match` for `DWELL_CYCLES` cycles. The tap is good iff `match` is 1 on every sampled cycle.
- EVAL, good tap: if no run is open, `run_start <= tap` and `run_len <= 1`; otherwise `run_len += 1`.
- EVAL, bad tap: close the open run.
- EVAL, last tap (largest multiple of `TAP_STEP` ≤ 511): close the open run, go to FINAL_SET. Otherwise `tap += TAP_STEP`, go to SET.
- Run close: if `run_len > best_width` (strictly greater; ties keep the earlier run), copy `run_start`/`run_len` to best.
- Center arithmetic: `best_center = best_start + (((best_width-1)*TAP_STEP) >> 1)`. Compute at 10+ bits, then truncate; the result is always ≤ 511.
- FINAL_SET:
  - if `best_width == 0`: set `fail`, `delay_target <= 0`.
  - else: `delay_target <= best_center`.
  - Then go to FINAL_SETTLE (`SETTLE_CYCLES`), then FINAL_WAIT (same ready/timeout rule), then DONE.
- DONE: `done=1`, `busy=0`.
- `busy` is 1 in every state except IDLE and DONE.

## Timing
- Reset values: `delay_target=0`, `busy=0`, `done=0`, `fail=0`, `timeout=0`, `best_center=0`, `best_width=0`; state IDLE.
- `start` sampled at edge N: `busy=1` and `done=0` from N+1. `delay_target` is driven at N+2 (SET executes at N+1).
- Per scan point: 1 (SET) + `SETTLE_CYCLES` + W (WAIT_RDY, W ≥ 1) + `DWELL_CYCLES` + 1 (EVAL) cycles.
- `match` is not sampled in SET, SETTLE, WAIT_RDY or EVAL.
- `start` while `busy`: ignored. `start` coincident with reset: reset wins.
- `rstb` low mid-scan: all outputs return to reset values on the next edge, and the scan is abandoned.
- Results are stable from `done` rising until the next `start`.

## Configuration
- `IDELAY_SCAN_ERRCNT_EN` defined: adds three ports.
  - `tap_result_valid` out 1: one-cycle pulse in EVAL.
  - `tap_result_tap` out 9.
  - `tap_result_errcnt` out 16: saturating count of `match==0` cycles in that dwell.
  - Good tap ⇔ errcnt == 0. Reset values 0.
- Not defined: ports absent; a 1-bit sticky error flag replaces the counter. Scan result is identical.

## Test plan
Common bench: setter model asserts `delay_ready` 12 cycles after each target change; `TAP_STEP=4`, `DWELL=64`, `SETTLE=16`.
- Single window, `match=1` for taps 100..199 → `best_width=25`, `best_center=148`, final `delay_target=148`, `fail=0`.
- Windows 20..59 and 300..379 → `best_width=20`, `best_center=338`.
- Equal windows 0..39 and 400..439 (10 points each) → earlier run kept: `best_center=18`.
- `match=0` throughout → `fail=1`, `timeout=0`, `best_width=0`, `delay_target=0`.
- Window 480..511 (run open at last tap 508) → `best_width=8`, `best_center=494`.
- `delay_ready` stuck 0 → `timeout=1`, `fail=1`, `done` at tap 0. Separately: reset asserted at tap 200 → all outputs 0 the next cycle. With `IDELAY_SCAN_ERRCNT_EN`, one `match` drop at tap 8 → `tap_result_errcnt=1` for tap 8.
